// File: rtl/gpio_in_capture_if.sv
// Register access bus between the bus-side controller (master) and gpio_in_capture (slave).
// Reads return one cycle after rd_en; writes take effect on the strobe edge.
interface gpio_in_capture_if #(
  parameter int WIDTH = 16
);
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [1:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/gpio_in_capture.sv
// GPIO input sampler: synchroniser, per-pin edge detect into sticky W1C status, level irq.
// Pin-to-irq latency SYNC_STAGES+1 edges; reads return one cycle after rd_en, no backpressure.
module gpio_in_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_pin,
  input  logic [WIDTH-1:0] gpio_dir,
  gpio_in_capture_if.slave bus,
  output logic             irq
);

  localparam logic [1:0] A_IN_DATA = 2'd0;
  localparam logic [1:0] A_RISE_EN = 2'd1;
  localparam logic [1:0] A_FALL_EN = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_status;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_in_data;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rd_mux;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= gpio_pin;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      // prev follows every pin so a dir flip to input never looks like an edge
      r_prev <= w_sync;
    end
  end

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_in_data = w_sync & ~gpio_dir;
  assign w_rise    =  w_sync & ~r_prev & ~gpio_dir & r_rise_en;
  assign w_fall    = ~w_sync &  r_prev & ~gpio_dir & r_fall_en;
  assign w_clr     = (bus.wr_en && bus.wr_addr == A_STATUS) ? bus.wr_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_status  <= '0;
    end else begin
      if (bus.wr_en && bus.wr_addr == A_RISE_EN) r_rise_en <= bus.wr_data;
      if (bus.wr_en && bus.wr_addr == A_FALL_EN) r_fall_en <= bus.wr_data;
      // a new edge in the same cycle as its clear keeps the bit set
      r_status <= (r_status & ~w_clr) | w_rise | w_fall;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus.rd_addr)
      A_IN_DATA: w_rd_mux = w_in_data;
      A_RISE_EN: w_rd_mux = r_rise_en;
      A_FALL_EN: w_rd_mux = r_fall_en;
      A_STATUS:  w_rd_mux = r_status;
      default:   w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) r_rd_data <= w_rd_mux;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign irq          = |r_status;

endmodule

// File: tb/tb_gpio_in_capture.sv
// Directed bench for gpio_in_capture: reads are scored through an expected-data queue.
module tb_gpio_in_capture;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] gpio_pin;
  logic [15:0] gpio_dir;
  logic        irq;

  gpio_in_capture_if #(.WIDTH(16)) bus ();

  gpio_in_capture #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .gpio_pin (gpio_pin),
    .gpio_dir (gpio_dir),
    .bus      (bus.slave),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q[$];
  int n_cmp   = 0;
  int n_err   = 0;
  int n_reads = 0;
  int n_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] e);
    exp_q.push_back(e);
    n_reads++;
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    tick();
    bus.rd_en   = 1'b0;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: pops one expectation per rd_valid cycle
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (bus.rd_valid === 1'b1) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rd_unexpected: got data %h with no read pending at %0t", bus.rd_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", 32'(bus.rd_data), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ev [4];
    reset       = 1'b1;
    gpio_pin    = 16'hFFFF;
    gpio_dir    = 16'h0000;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 2'd0;
    bus.wr_data = 16'h0000;
    bus.rd_en   = 1'b0;
    bus.rd_addr = 2'd0;

    // 1. reset
    settle(2);
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    reset = 1'b0;
    settle(2);
    rd(2'd0, 16'hFFFF);
    rd(2'd3, 16'h0000);
    chk("post_reset_irq", 32'(irq), 32'd0);

    // 2. rising edge on pin0 with exact latency
    gpio_pin = 16'h0000;
    settle(3);
    wr(2'd1, 16'h0001);
    gpio_pin = 16'h0001;
    tick();
    chk("rise_irq_k", 32'(irq), 32'd0);
    tick();
    chk("rise_irq_k1", 32'(irq), 32'd0);
    tick();
    chk("rise_irq_k2", 32'(irq), 32'd1);
    rd(2'd3, 16'h0001);
    wr(2'd3, 16'h0001);
    chk("w1c_irq", 32'(irq), 32'd0);

    // 3. direction mask
    gpio_pin = 16'h0000;
    gpio_dir = 16'hFF00;
    settle(3);
    wr(2'd1, 16'hFFFF);
    wr(2'd2, 16'hFFFF);
    gpio_pin = 16'hFFFF;
    settle(3);
    chk("dir_irq", 32'(irq), 32'd1);
    rd(2'd3, 16'h00FF);
    rd(2'd0, 16'h00FF);
    gpio_dir = 16'h0000;
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0000);
    wr(2'd3, 16'hFFFF);
    chk("dir_clear_irq", 32'(irq), 32'd0);

    // 4. falling edge on pin15, then both-edge pulse on pin3
    wr(2'd2, 16'h8000);
    gpio_pin = 16'h7FFF;
    settle(3);
    chk("fall_irq", 32'(irq), 32'd1);
    rd(2'd3, 16'h8000);
    wr(2'd3, 16'h8000);
    gpio_pin = 16'h7FF7;
    settle(3);
    chk("fall_unenabled_irq", 32'(irq), 32'd0);
    wr(2'd1, 16'h0008);
    wr(2'd2, 16'h8008);
    gpio_pin = 16'h7FFF;
    settle(4);
    chk("both_rise_irq", 32'(irq), 32'd1);
    gpio_pin = 16'h7FF7;
    settle(3);
    rd(2'd3, 16'h0008);
    chk("both_sticky_irq", 32'(irq), 32'd1);
    wr(2'd3, 16'h0008);
    chk("both_clear_irq", 32'(irq), 32'd0);

    // 5. clear colliding with a new rising edge on pin4
    wr(2'd1, 16'h0010);
    wr(2'd2, 16'h0000);
    gpio_pin = 16'h7FE7;
    settle(3);
    chk("col_pre_irq", 32'(irq), 32'd0);
    gpio_pin = 16'h7FF7;
    settle(3);
    chk("col_first_irq", 32'(irq), 32'd1);
    gpio_pin = 16'h7FE7;
    settle(3);
    gpio_pin = 16'h7FF7;
    tick();
    tick();
    wr(2'd3, 16'h0010);
    chk("col_irq", 32'(irq), 32'd1);
    rd(2'd3, 16'h0010);
    chk("col_irq_hold", 32'(irq), 32'd1);
    wr(2'd3, 16'h0010);
    chk("col_clear_irq", 32'(irq), 32'd0);

    // 6. back-to-back reads with a write to RISE_EN during its read
    wr(2'd2, 16'h0300);
    ev[0] = 16'h7FF7;
    ev[1] = 16'h0010;
    ev[2] = 16'h0300;
    ev[3] = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      bus.rd_en   = (i < 4);
      bus.rd_addr = i[1:0];
      if (i < 4) begin
        exp_q.push_back(ev[i]);
        n_reads++;
      end
      bus.wr_en   = (i == 1);
      bus.wr_addr = 2'd1;
      bus.wr_data = 16'h00AA;
      tick();
      chk("pipe_rd_valid", 32'(bus.rd_valid), (i < 4) ? 32'd1 : 32'd0);
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    rd(2'd1, 16'h00AA);

    // Reset while a read is being issued drops that read
    bus.rd_en   = 1'b1;
    bus.rd_addr = 2'd2;
    reset       = 1'b1;
    tick();
    bus.rd_en   = 1'b0;
    chk("rst_drop_rd_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    reset = 1'b0;
    rd(2'd1, 16'h0000);
    rd(2'd2, 16'h0000);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    settle(2);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    chk("valid_count", 32'(n_valid), 32'(n_reads));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gpio_in_capture.md
Name: gpio_in_capture

Overview:
Input-side companion to the GPIO direction register. It samples the GPIO pins configured as inputs and synchronises them into the clk domain. It detects rising and falling edges per pin, latches them into sticky W1C status bits, and raises a level interrupt. A simple register read/write port exposes pin data, edge enables and status to the bus-side controller.

Parameters:
WIDTH, 16, number of GPIO pins; must match the gpio_dir register width.
SYNC_STAGES, 2, number of synchroniser flops on gpio_pin; legal values are 2 or 3.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
gpio_pin  input  WIDTH  asynchronous pad inputs.
gpio_dir  input  WIDTH  direction per pin from the direction register: 1 = output, 0 = input.
wr_en  input  1  register write strobe, one cycle.
wr_addr  input  2  write address.
wr_data  input  WIDTH  write data.
rd_en  input  1  register read strobe, one cycle.
rd_addr  input  2  read address.
rd_data  output  WIDTH  read data; valid while rd_valid = 1, holds its last value otherwise.
rd_valid  output  1  one-cycle pulse, one clock after rd_en.
irq  output  1  level interrupt = OR of all STATUS bits.

Behaviour:
- Register map:
  - 0 IN_DATA: read-only; synchronised pin value AND ~gpio_dir, so output pins read 0. Writes are ignored.
  - 1 RISE_EN: read/write; per-pin rising-edge enable.
  - 2 FALL_EN: read/write; per-pin falling-edge enable.
  - 3 STATUS: read; write-1-to-clear. Writing 0 to a bit has no effect on it.
- Reset, applied on the first rising clk edge with reset = 1:
  - Synchroniser flops, prev register, RISE_EN, FALL_EN, STATUS, rd_data and rd_valid all go to 0.
  - irq = 0.
  - Reset asserted mid-operation discards any pending read; no rd_valid is issued for it.
- Synchroniser: SYNC_STAGES flops in series per bit. sync denotes the last stage. prev <= sync every cycle, for every bit regardless of gpio_dir.
- Edge detect, per bit i:
  - rise[i] = sync[i] & ~prev[i] & ~gpio_dir[i] & RISE_EN[i]
  - fall[i] = ~sync[i] & prev[i] & ~gpio_dir[i] & FALL_EN[i]
- STATUS update: STATUS[i] <= (STATUS[i] & ~clr[i]) | rise[i] | fall[i], where clr = wr_data when wr_en = 1 and wr_addr = 3, else 0.
  - Set and clear of the same bit in the same cycle: set wins, bit stays 1.
- Latency (SYNC_STAGES = 2): a pin change stable before clk edge k appears in sync after edge k+1. STATUS and irq assert after edge k+2. irq is driven combinationally from STATUS, with no extra flop.
- Because prev tracks sync for all pins, switching a pin from output to input creates no spurious edge. The edge only registers if sync differs from prev in the cycle evaluated.
- RISE_EN/FALL_EN writes take effect from the cycle after the write edge. Clearing an enable does not clear STATUS.
- Reads:
  - rd_en at edge n gives rd_data and rd_valid = 1 after edge n+1; rd_valid is 1 for exactly one cycle.
  - Back-to-back reads on consecutive cycles are supported, one result per cycle.
  - Reading STATUS does not clear it.
- Simultaneous rd_en and wr_en to the same address: the read returns the value before the write.
- A pulse shorter than one clk period may be missed; this is by design, with no glitch capture.
- Upper WIDTH bits of wr_data are used in full. There are no reserved bits.

Test Plan:
1. Reset: with reset = 1 for 2 cycles and gpio_pin = 16'hFFFF, then release with all enables 0 → irq stays 0, STATUS reads 16'h0000, IN_DATA reads 16'hFFFF after 2 cycles (gpio_dir = 0).
2. Rising edge: RISE_EN = 16'h0001, gpio_dir = 0, pin0 goes 0→1 before edge k → irq = 1 after edge k+2, STATUS reads 16'h0001. Write 16'h0001 to STATUS → irq = 0 the next cycle.
3. Direction mask: gpio_dir = 16'hFF00, RISE_EN = FALL_EN = 16'hFFFF, gpio_pin toggles 16'h0000→16'hFFFF → STATUS = 16'h00FF, IN_DATA = 16'h00FF.
4. Falling edge and both-edge: FALL_EN = 16'h8000, pin15 goes 1→0 → STATUS[15] = 1; pin3 with RISE_EN = FALL_EN = 1 pulsed high for 4 cycles → STATUS[3] set after the rising edge and remains set.
5. Clear collision: a W1C write of 16'h0010 in the same cycle as a new rising edge on pin4 → STATUS[4] remains 1 and irq remains 1.
6. Read pipelining: rd_en on 4 consecutive cycles for addresses 0, 1, 2, 3 → rd_valid is high for 4 cycles starting one cycle later, and the data match each register. A concurrent write of 16'h00AA to address 1 during its read returns the old RISE_EN value.
